flick_arbiter_ctrl: RTL and testbench

// - Sequencer in front of BoundFlasher_Mealy. Collects flick requests from NREQ sources, arbitrates

---
 rtl/flasher_pkg.sv | 20 ++
 rtl/rr_pick.sv | 32 +++
 rtl/flick_arbiter_ctrl.sv | 136 +++++++++++++
 tb/tb_flick_arbiter_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/flasher_pkg.sv
// rtl/flasher_pkg.sv - lamp kickback constants and arbiter FSM encoding
package flasher_pkg;

   localparam logic [15:0] LAMPS_OFF = 16'h0000;
   localparam logic [15:0] LAMPS_L5  = 16'h003F;
   localparam logic [15:0] LAMPS_L10 = 16'h07FF;
   localparam logic [15:0] LAMPS_ALL = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_t;

   // True while the lamp vector rests on a kickback value where a flick is honoured
   function automatic logic in_window(input logic [15:0] lamps);
      return (lamps == LAMPS_OFF) || (lamps == LAMPS_L5) || (lamps == LAMPS_L10);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin priority picker over a pending vector
module rr_pick #(
   parameter int NREQ  = 4,
   parameter int PTR_W = 2
) (
   input  logic [NREQ-1:0]  pending,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  winner,
   output logic [PTR_W-1:0] winner_idx,
   output logic             valid
);

   function automatic logic [PTR_W-1:0] wrap_idx(input int base, input int off);
      int s;
      s = (base + off) % NREQ;
      return PTR_W'(s);
   endfunction

   // First set pending bit at or above ptr, wrapping at NREQ
   always_comb begin
      valid      = 1'b0;
      winner_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!valid && pending[wrap_idx(int'(ptr), k)]) begin
            valid      = 1'b1;
            winner_idx = wrap_idx(int'(ptr), k);
         end
      end
      winner = valid ? ({{(NREQ-1){1'b0}}, 1'b1} << winner_idx) : '0;
   end

endmodule

// File: rtl/flick_arbiter_ctrl.sv
// rtl/flick_arbiter_ctrl.sv - round-robin flick sequencer in front of the lamp flasher
module flick_arbiter_ctrl #(
   parameter int NREQ     = 4,
   parameter int HOLD_CYC = 2,
   parameter int TIMEOUT  = 255,
   parameter int RST_HOLD = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic [15:0]     lamps,
   output logic            flick,
   output logic            flasher_rst,
   output logic [NREQ-1:0] gnt,
   output logic            busy,
   output logic [7:0]      kick_count
);
   import flasher_pkg::*;

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_t       state, state_next;
   logic [NREQ-1:0]  req_q;
   logic [NREQ-1:0]  pending;
   logic [NREQ-1:0]  rise;
   logic [NREQ-1:0]  grant_mask;
   logic [PTR_W-1:0] rr_ptr;
   logic [NREQ-1:0]  pick_onehot;
   logic [PTR_W-1:0] pick_idx;
   logic             pick_valid;
   logic [15:0]      lamp_snap;
   logic [7:0]       hold_cnt;
   logic [7:0]       wait_cnt;
   logic             do_grant;
   logic             win;
   logic             sync1, sync2;
   logic [7:0]       rst_cnt;

   assign rise       = req & ~req_q;
   assign win        = in_window(lamps);
   assign grant_mask = do_grant ? pick_onehot : '0;

   rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
      .pending    (pending),
      .ptr        (rr_ptr),
      .winner     (pick_onehot),
      .winner_idx (pick_idx),
      .valid      (pick_valid)
   );

   // Flasher reset: two-flop release, then stretched RST_HOLD cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1       <= 1'b0;
         sync2       <= 1'b0;
         rst_cnt     <= 8'(RST_HOLD);
         flasher_rst <= 1'b1;
      end else begin
         sync1 <= 1'b1;
         sync2 <= sync1;
         if (!sync2)
            rst_cnt <= 8'(RST_HOLD);
         else if (rst_cnt != 8'd0)
            rst_cnt <= rst_cnt - 8'd1;
         flasher_rst <= !(sync2 && (rst_cnt == 8'd0));
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // Next state; a grant only starts on an open window with the flasher out of reset
   always_comb begin
      state_next = state;
      do_grant   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_valid && win && !flasher_rst) begin
               state_next = ST_GRANT;
               do_grant   = 1'b1;
            end
         end
         ST_GRANT: begin
            if (hold_cnt == 8'd0)
               state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if ((lamps != lamp_snap) || (wait_cnt == 8'(TIMEOUT - 1)))
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Request capture, grant bookkeeping and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_q      <= '0;
         pending    <= '0;
         rr_ptr     <= '0;
         lamp_snap  <= '0;
         hold_cnt   <= '0;
         wait_cnt   <= '0;
         kick_count <= '0;
         gnt        <= '0;
         flick      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         req_q   <= req;
         // a fresh edge on the served source survives the clear
         pending <= (pending & ~grant_mask) | rise;
         gnt     <= grant_mask;
         flick   <= (state_next == ST_GRANT);
         busy    <= (state_next != ST_IDLE);
         if (do_grant) begin
            rr_ptr    <= (pick_idx == PTR_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            lamp_snap <= lamps;
            hold_cnt  <= 8'(HOLD_CYC - 1);
            if (kick_count != 8'hFF)
               kick_count <= kick_count + 8'd1;
         end else if ((state == ST_GRANT) && (hold_cnt != 8'd0)) begin
            hold_cnt <= hold_cnt - 8'd1;
         end
         if (state != ST_WAIT)
            wait_cnt <= 8'd0;
         else
            wait_cnt <= wait_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_flick_arbiter_ctrl.sv
// tb/tb_flick_arbiter_ctrl.sv - directed self-checking bench for flick_arbiter_ctrl
module tb_flick_arbiter_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req = 4'b0000;
   logic [15:0] lamps = 16'h001F;
   logic        flick, flasher_rst, busy;
   logic [3:0]  gnt;
   logic [7:0]  kick_count;
   int          checks = 0;
   int          failures = 0;
   logic        saw_flick, saw_gnt;

   always #5 clk = ~clk;

   flick_arbiter_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .lamps       (lamps),
      .flick       (flick),
      .flasher_rst (flasher_rst),
      .gnt         (gnt),
      .busy        (busy),
      .kick_count  (kick_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rst_release_check();
      for (int i = 0; i < 6; i++) begin
         step();
         chk("frst_hold", flasher_rst, 1'b1);
         chk("frst_flick", flick, 1'b0);
      end
      step();
      chk("frst_low", flasher_rst, 1'b0);
      chk("frst_kick", kick_count, 8'd0);
   endtask

   task automatic serve(input logic [3:0] eg, input logic [7:0] ek, input logic [15:0] nl);
      int n;
      n = 0;
      while (gnt == 4'b0000 && n < 40) begin
         step();
         n++;
      end
      chk("serve_gnt", gnt, eg);
      chk("serve_flick1", flick, 1'b1);
      chk("serve_kick", kick_count, ek);
      step();
      chk("serve_flick2", flick, 1'b1);
      chk("serve_gnt_pulse", gnt, 4'b0000);
      step();
      chk("serve_flick_off", flick, 1'b0);
      chk("serve_wait_busy", busy, 1'b1);
      lamps = nl;
      step();
      chk("serve_wait_exit", busy, 1'b0);
   endtask

   initial begin
      // reset values
      step();
      step();
      chk("rst_flick", flick, 1'b0);
      chk("rst_gnt", gnt, 4'b0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_kick", kick_count, 8'd0);
      chk("rst_frst", flasher_rst, 1'b1);
      rst = 1'b1;
      rst_release_check();

      // round-robin from pointer 0 with windows stepping
      req = 4'b1011;
      step();
      step();
      step();
      chk("closed_no_gnt", gnt, 4'b0000);
      chk("closed_no_flick", flick, 1'b0);
      lamps = 16'h0000;
      serve(4'b0001, 8'd1, 16'h003F);
      serve(4'b0010, 8'd2, 16'h07FF);
      serve(4'b1000, 8'd3, 16'h001F);
      req = 4'b0000;
      step();
      req = 4'b1001;
      step();
      lamps = 16'h0000;
      serve(4'b0001, 8'd4, 16'h001F);
      lamps = 16'h07FF;
      serve(4'b1000, 8'd5, 16'h001F);
      req = 4'b0000;

      // request held off by closed window, then timeout in WAIT
      req = 4'b0100;
      step();
      req = 4'b0000;
      saw_flick = 1'b0;
      saw_gnt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         saw_flick |= flick;
         saw_gnt |= |gnt;
      end
      chk("nowin_flick", saw_flick, 1'b0);
      chk("nowin_gnt", saw_gnt, 1'b0);
      lamps = 16'h07FF;
      step();
      chk("win_gnt", gnt, 4'b0100);
      chk("win_flick", flick, 1'b1);
      chk("win_kick", kick_count, 8'd6);
      step();
      chk("win_flick2", flick, 1'b1);
      step();
      chk("win_flick_off", flick, 1'b0);
      chk("win_wait", busy, 1'b1);
      saw_flick = 1'b0;
      for (int i = 0; i < 254; i++) begin
         step();
         saw_flick |= flick;
      end
      chk("timeout_not_early", busy, 1'b1);
      step();
      chk("timeout_exit", busy, 1'b0);
      chk("timeout_kick", kick_count, 8'd6);
      for (int i = 0; i < 10; i++) begin
         step();
         saw_flick |= flick;
      end
      chk("no_reflick", saw_flick, 1'b0);

      // re-rise in the cycle its pending clears keeps the request
      lamps = 16'h001F;
      req = 4'b0001;
      step();
      req = 4'b0000;
      step();
      lamps = 16'h0000;
      req = 4'b0001;
      serve(4'b0001, 8'd7, 16'h003F);
      serve(4'b0001, 8'd8, 16'h001F);
      req = 4'b0000;
      step();

      // edge-to-grant latency, then reset mid-GRANT
      lamps = 16'h0000;
      req = 4'b0100;
      step();
      chk("lat_n1", gnt, 4'b0000);
      step();
      chk("lat_n2_gnt", gnt, 4'b0100);
      chk("lat_n2_flick", flick, 1'b1);
      chk("lat_kick", kick_count, 8'd9);
      rst = 1'b0;
      req = 4'b0000;
      #1;
      chk("mid_rst_flick", flick, 1'b0);
      chk("mid_rst_gnt", gnt, 4'b0000);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_kick", kick_count, 8'd0);
      chk("mid_rst_frst", flasher_rst, 1'b1);
      rst = 1'b1;
      rst_release_check();
      saw_gnt = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         saw_gnt |= |gnt;
      end
      chk("pending_lost", saw_gnt, 1'b0);
      chk("pending_lost_kick", kick_count, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
